// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle controller: opcode/function encodings,
// FSM states, PC target selects, ALU operation codes and the decode bundle.
package multicycle_ctrl_pkg;

  localparam int OP_W   = 5;
  localparam int FUNC_W = 4;
  localparam int ALU_W  = 4;

  typedef enum logic [OP_W-1:0] {
    RTYPE_op = 5'd0,
    ADDI_op  = 5'd1,
    SUBI_op  = 5'd2,
    ANDI_op  = 5'd3,
    ORI_op   = 5'd4,
    XORI_op  = 5'd5,
    SLLI_op  = 5'd6,
    SRLI_op  = 5'd7,
    SLAI_op  = 5'd8,
    SRAI_op  = 5'd9,
    LUI_op   = 5'd10,
    LLI_op   = 5'd11,
    SLTI_op  = 5'd12,
    BEQ_op   = 5'd13,
    BNE_op   = 5'd14,
    LWR_op   = 5'd15,
    LWI_op   = 5'd16,
    SWR_op   = 5'd17,
    SWI_op   = 5'd18,
    JUMP_op  = 5'd19,
    JAL_op   = 5'd20,
    RET_op   = 5'd21
  } op_code;

  typedef enum logic [FUNC_W-1:0] {
    ADD_f = 4'd0,
    SUB_f = 4'd1,
    AND_f = 4'd2,
    OR_f  = 4'd3,
    XOR_f = 4'd4,
    SLL_f = 4'd5,
    SRL_f = 4'd6,
    SLA_f = 4'd7,
    SRA_f = 4'd8,
    SLT_f = 4'd11
  } func_code;

  typedef logic [ALU_W-1:0] alu_op_d;

  localparam alu_op_d ALU_ADD = 4'd0;
  localparam alu_op_d ALU_SUB = 4'd1;
  localparam alu_op_d ALU_AND = 4'd2;
  localparam alu_op_d ALU_OR  = 4'd3;
  localparam alu_op_d ALU_XOR = 4'd4;
  localparam alu_op_d ALU_SLL = 4'd5;
  localparam alu_op_d ALU_SRL = 4'd6;
  localparam alu_op_d ALU_SLA = 4'd7;
  localparam alu_op_d ALU_SRA = 4'd8;
  localparam alu_op_d ALU_LUI = 4'd9;
  localparam alu_op_d ALU_LLI = 4'd10;
  localparam alu_op_d ALU_CMP = 4'd11;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    RET    = 2'd3
  } pc_sel_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_BR  = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_J   = 3'd4,
    CLS_JAL = 3'd5,
    CLS_RET = 3'd6,
    CLS_ILL = 3'd7
  } instr_class_t;

  // Static per-instruction datapath selects; the FSM decides when they show.
  typedef struct packed {
    instr_class_t cls;
    alu_op_d      alu_op;
    logic         mux_imm;
    logic         mux_alu;
    logic         sign_zero;
    logic         mux_rd;
    logic         mux_D;
    logic         mux_dm_ad;
    logic         mux_dmq_pc;
    logic         mux_jtype_itype;
    logic         beq_ben;
  } ctrl_sel_t;

  function automatic logic is_shift(input alu_op_d a);
    return (a == ALU_SLL) || (a == ALU_SRL) || (a == ALU_SLA) || (a == ALU_SRA);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational decode of the registered op/func fields into the
// static datapath select bundle and an instruction class.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output ctrl_sel_t         sel
);

  always_comb begin
    sel     = '0;
    sel.cls = CLS_ILL;
    case (op)
      RTYPE_op: begin
        sel.cls = CLS_ALU;
        case (func)
          ADD_f:   sel.alu_op = ALU_ADD;
          SUB_f:   sel.alu_op = ALU_SUB;
          AND_f:   sel.alu_op = ALU_AND;
          OR_f:    sel.alu_op = ALU_OR;
          XOR_f:   sel.alu_op = ALU_XOR;
          SLL_f:   sel.alu_op = ALU_SLL;
          SRL_f:   sel.alu_op = ALU_SRL;
          SLA_f:   sel.alu_op = ALU_SLA;
          SRA_f:   sel.alu_op = ALU_SRA;
          SLT_f:   sel.alu_op = ALU_CMP;
          default: sel.cls    = CLS_ILL;
        endcase
        sel.mux_imm = is_shift(sel.alu_op);
        sel.mux_alu = is_shift(sel.alu_op);
      end
      ADDI_op, SUBI_op, ANDI_op, ORI_op, XORI_op, SLLI_op, SRLI_op,
      SLAI_op, SRAI_op, LUI_op, LLI_op, SLTI_op: begin
        sel.cls     = CLS_ALU;
        sel.mux_alu = 1'b1;
        sel.mux_rd  = 1'b1;
        case (op)
          ADDI_op: sel.alu_op = ALU_ADD;
          SUBI_op: sel.alu_op = ALU_SUB;
          ANDI_op: sel.alu_op = ALU_AND;
          ORI_op:  sel.alu_op = ALU_OR;
          XORI_op: sel.alu_op = ALU_XOR;
          SLLI_op: sel.alu_op = ALU_SLL;
          SRLI_op: sel.alu_op = ALU_SRL;
          SLAI_op: sel.alu_op = ALU_SLA;
          SRAI_op: sel.alu_op = ALU_SRA;
          LUI_op:  sel.alu_op = ALU_LUI;
          LLI_op:  sel.alu_op = ALU_LLI;
          default: sel.alu_op = ALU_CMP;
        endcase
        sel.mux_imm   = is_shift(sel.alu_op);
        sel.sign_zero = (op == LUI_op) || (op == LLI_op);
      end
      BEQ_op, BNE_op: begin
        sel.cls     = CLS_BR;
        sel.alu_op  = ALU_CMP;
        sel.beq_ben = (op == BNE_op);
      end
      LWR_op: begin
        sel.cls   = CLS_LD;
        sel.mux_D = 1'b1;
      end
      LWI_op: begin
        sel.cls       = CLS_LD;
        sel.mux_D     = 1'b1;
        sel.mux_dm_ad = 1'b1;
      end
      SWR_op: sel.cls = CLS_ST;
      SWI_op: begin
        sel.cls       = CLS_ST;
        sel.mux_dm_ad = 1'b1;
      end
      JUMP_op: sel.cls = CLS_J;
      JAL_op: begin
        sel.cls             = CLS_JAL;
        sel.mux_rd          = 1'b1;
        sel.mux_D           = 1'b1;
        sel.mux_dmq_pc      = 1'b1;
        sel.mux_jtype_itype = 1'b1;
      end
      RET_op:  sel.cls = CLS_RET;
      default: sel.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with one-cycle
// write strobes, data-memory ack timeout and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int DM_TIMEOUT = 15,
  parameter int TMO_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  input  logic                dm_ack,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [ALU_W-1:0]    alu_op,
  output logic                mux_imm,
  output logic                mux_alu,
  output logic                sign_zero,
  output logic                mux_rd,
  output logic                mux_D,
  output logic                mux_dm_ad,
  output logic                mux_dmq_pc,
  output logic                mux_jtype_itype,
  output logic                branch,
  output logic                beq_ben,
  output logic                rf_we,
  output logic                dm_re,
  output logic                dm_we,
  output logic                illegal,
  output logic                dm_timeout,
  output logic [CNT_W-1:0]    retired,
  output logic [2:0]          dbg_state
);

  // Handshake: an instruction transfers in a cycle where instr_valid and
  // instr_ready are both high; instr_ready is high only in FETCH (and not in rst).

  ctrl_state_t         state, state_n;
  logic [OP_W-1:0]     op_r;
  logic [FUNC_W-1:0]   func_r;
  logic [TMO_W-1:0]    wait_cnt;
  logic                retire, set_ill, set_tmo, mem_wait;
  ctrl_sel_t           dec;

  multicycle_ctrl_decode u_ctrl_decode (
    .op   (op_r),
    .func (func_r),
    .sel  (dec)
  );

  assign dbg_state = state;
  assign mem_wait  = (state == MEM_RD || state == MEM_WR) && (state_n == state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      op_r       <= '0;
      func_r     <= '0;
      wait_cnt   <= '0;
      retired    <= '0;
      illegal    <= 1'b0;
      dm_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_we) begin
        op_r   <= op;
        func_r <= func;
      end
      // Restarts at 0 on every memory-state entry.
      wait_cnt <= mem_wait ? wait_cnt + TMO_W'(1) : '0;
      if (retire)  retired    <= retired + CNT_W'(1);
      if (set_ill) illegal    <= 1'b1;
      if (set_tmo) dm_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_n         = state;
    instr_ready     = 1'b0;
    ir_we           = 1'b0;
    pc_we           = 1'b0;
    pc_sel          = SEQ;
    alu_op          = '0;
    mux_imm         = 1'b0;
    mux_alu         = 1'b0;
    sign_zero       = 1'b0;
    mux_rd          = 1'b0;
    mux_D           = 1'b0;
    mux_dm_ad       = 1'b0;
    mux_dmq_pc      = 1'b0;
    mux_jtype_itype = 1'b0;
    branch          = 1'b0;
    beq_ben         = 1'b0;
    rf_we           = 1'b0;
    dm_re           = 1'b0;
    dm_we           = 1'b0;
    retire          = 1'b0;
    set_ill         = 1'b0;
    set_tmo         = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = !rst;
        if (instr_valid && !rst) begin
          ir_we   = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        case (dec.cls)
          CLS_ILL: begin
            set_ill = 1'b1;
            state_n = TRAP;
          end
          CLS_J, CLS_RET: begin
            pc_we   = 1'b1;
            pc_sel  = (dec.cls == CLS_J) ? JUMP : RET;
            retire  = 1'b1;
            state_n = FETCH;
          end
          default: state_n = EXEC;
        endcase
      end
      EXEC: begin
        alu_op    = dec.alu_op;
        mux_imm   = dec.mux_imm;
        mux_alu   = dec.mux_alu;
        sign_zero = dec.sign_zero;
        mux_rd    = dec.mux_rd;
        mux_dm_ad = dec.mux_dm_ad;
        case (dec.cls)
          CLS_BR: begin
            branch  = 1'b1;
            beq_ben = dec.beq_ben;
            pc_we   = 1'b1;
            pc_sel  = BRANCH;
            retire  = 1'b1;
            state_n = FETCH;
          end
          CLS_LD:  state_n = MEM_RD;
          CLS_ST:  state_n = MEM_WR;
          default: state_n = WB;
        endcase
      end
      MEM_RD, MEM_WR: begin
        dm_re     = (state == MEM_RD);
        dm_we     = (state == MEM_WR);
        mux_dm_ad = dec.mux_dm_ad;
        if (dm_ack) begin
          if (state == MEM_RD) begin
            state_n = WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_n = FETCH;
          end
        end else if (wait_cnt == TMO_W'(DM_TIMEOUT - 1)) begin
          set_tmo = 1'b1;
          state_n = TRAP;
        end
      end
      WB: begin
        rf_we           = 1'b1;
        pc_we           = 1'b1;
        pc_sel          = (dec.cls == CLS_JAL) ? JUMP : SEQ;
        mux_rd          = dec.mux_rd;
        mux_D           = dec.mux_D;
        mux_dmq_pc      = dec.mux_dmq_pc;
        mux_jtype_itype = dec.mux_jtype_itype;
        retire          = 1'b1;
        state_n         = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

endmodule
